count_run_arbiter: RTL and testbench

- Shares one loadable up-counter (COUNTER behind the AASD reset synchroniser) between two requesters.
- Each requester asks for a "run": load a start value, count up to a stop value, then get a one-cycle completion pulse.
- Arbitrates round-robin, drives the counter's LOAD/ENABLE/DATA, watches COUNT for the stop match, and includes a watchdog against a stuck counter.
- Sits beside the counter in the top level; the counter's COUNT output feeds back into this block.

---
 rtl/count_run_arbiter.sv | 109 ++++++++++
 tb/tb_count_run_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_run_arbiter.sv
// Round-robin owner of a shared loadable up-counter: loads a start value, lets it
// count to a stop value, then pulses DONE for the owner (ERR set if the watchdog fired).
module count_run_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 2**WIDTH + 1
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] START0,
  input  logic [WIDTH-1:0] STOP0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] START1,
  input  logic [WIDTH-1:0] STOP1,
  input  logic [WIDTH-1:0] COUNT,
  output logic             CTR_LOAD,
  output logic             CTR_ENABLE,
  output logic [WIDTH-1:0] CTR_DATA,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic             ERR,
  output logic             BUSY
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Handshake: REQx is a level sampled only in IDLE; GNTx stays high from the
  // load cycle through the DONE pulse, and inputs are ignored while granted.
  state_t           state;
  logic             owner;
  logic             last;
  logic [WIDTH-1:0] stop_q;
  logic [TW-1:0]    timer;
  logic             pick;
  logic             match;
  logic             expired;

  // With both requesting, the one that did not win last time gets the counter.
  assign pick    = REQ1 && (!REQ0 || !last);
  assign match   = (COUNT == stop_q);
  assign expired = (timer == TW'(TIMEOUT - 1)) && !match;

  assign CTR_ENABLE = (state == RUN) && !match && !expired;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      stop_q   <= '0;
      timer    <= '0;
      CTR_LOAD <= 1'b0;
      CTR_DATA <= '0;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            owner    <= pick;
            last     <= pick;
            CTR_DATA <= pick ? START1 : START0;
            stop_q   <= pick ? STOP1 : STOP0;
            CTR_LOAD <= 1'b1;
            GNT0     <= !pick;
            GNT1     <= pick;
            BUSY     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          CTR_LOAD <= 1'b0;
          timer    <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (match || expired) begin
            ERR   <= expired;
            DONE0 <= !owner;
            DONE1 <= owner;
            state <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          DONE0 <= 1'b0;
          DONE1 <= 1'b0;
          ERR   <= 1'b0;
          GNT0  <= 1'b0;
          GNT1  <= 1'b0;
          BUSY  <= 1'b0;
          timer <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_run_arbiter.sv
// Bench for count_run_arbiter: a timeline model of each run (load, k enables, done)
// is compared against the DUT every cycle, with a DONE scoreboard and literal pins.
module tb_count_run_arbiter;

  localparam int W       = 8;
  localparam int TIMEOUT = 2**W + 1;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic         REQ0 = 1'b0, REQ1 = 1'b0;
  logic [W-1:0] START0 = '0, STOP0 = '0, START1 = '0, STOP1 = '0;
  logic [W-1:0] COUNT;
  logic         CTR_LOAD, CTR_ENABLE, GNT0, GNT1, DONE0, DONE1, ERR, BUSY;
  logic [W-1:0] CTR_DATA;

  // Counter stand-in, plus an override that freezes COUNT.
  logic [W-1:0] cnt = '0;
  logic         stuck = 1'b0;
  logic [W-1:0] stuck_val = '0;
  assign COUNT = stuck ? stuck_val : cnt;

  always @(posedge CLOCK) begin
    if (CTR_LOAD) cnt <= CTR_DATA;
    else if (CTR_ENABLE) cnt <= cnt + 8'd1;
  end

  count_run_arbiter #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .REQ0(REQ0), .START0(START0), .STOP0(STOP0),
    .REQ1(REQ1), .START1(START1), .STOP1(STOP1),
    .COUNT(COUNT),
    .CTR_LOAD(CTR_LOAD), .CTR_ENABLE(CTR_ENABLE), .CTR_DATA(CTR_DATA),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .ERR(ERR), .BUSY(BUSY)
  );

  // Clock block
  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int failures = 0;

  // Model: a run is a timeline of offsets d from the grant edge.
  bit           m_busy = 1'b0;
  bit           m_last = 1'b1;
  bit           m_owner = 1'b0;
  bit           m_err = 1'b0;
  int           m_d = 0;
  int           m_n = 0;
  logic [W-1:0] m_data = '0;

  // Scoreboard of expected DONE events: {err, owner}
  logic [1:0] exp_q[$];

  // Observation counters for the literal pins
  int obs_load, obs_en, obs_done0, obs_done1, obs_err, obs_busy;
  int count_at_done;
  bit saw_zero;
  bit prev_gnt0 = 1'b0, prev_gnt1 = 1'b0;
  int gnt_log[$];

  task automatic clear_obs();
    obs_load = 0; obs_en = 0; obs_done0 = 0; obs_done1 = 0;
    obs_err = 0; obs_busy = 0; count_at_done = -1; saw_zero = 1'b0;
    gnt_log.delete();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] s, p, k;
    if (RESET) begin
      m_busy = 1'b0; m_last = 1'b1; m_data = '0; exp_q.delete();
    end else if (!m_busy) begin
      if (REQ0 || REQ1) begin
        m_owner = (REQ0 && REQ1) ? !m_last : REQ1;
        m_last  = m_owner;
        m_busy  = 1'b1;
        m_d     = 0;
        s = m_owner ? START1 : START0;
        p = m_owner ? STOP1 : STOP0;
        m_data = s;
        if (stuck) begin
          m_err = (stuck_val != p);
          m_n   = m_err ? TIMEOUT - 1 : 0;
        end else begin
          k = p - s;
          m_n = int'(k);
          m_err = 1'b0;
        end
        exp_q.push_back({m_err, m_owner});
      end
    end else begin
      m_d++;
      if (m_d > m_n + 2) m_busy = 1'b0;
    end
  endtask

  task automatic compare();
    logic [W+7:0] act, exp;
    logic [1:0]   e;
    bit e_load, e_en, e_done;
    e_load = m_busy && (m_d == 0);
    e_en   = m_busy && (m_d >= 1) && (m_d <= m_n);
    e_done = m_busy && (m_d == m_n + 2);
    exp = {e_load, e_en, m_busy && !m_owner, m_busy && m_owner,
           e_done && !m_owner, e_done && m_owner, e_done && m_err, m_busy, m_data};
    act = {CTR_LOAD, CTR_ENABLE, GNT0, GNT1, DONE0, DONE1, ERR, BUSY, CTR_DATA};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t {load,en,g0,g1,d0,d1,err,busy,data} got %b expected %b",
               $time, act, exp);
    end
    if (DONE0 || DONE1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL done_event t=%0t got unexpected DONE {%b,%b} expected none", $time, DONE0, DONE1);
      end else begin
        e = exp_q.pop_front();
        if ({ERR, DONE1} != e || (DONE0 && DONE1)) begin
          failures++;
          $display("FAIL done_event t=%0t got err=%b d0=%b d1=%b expected err=%b owner=%b",
                   $time, ERR, DONE0, DONE1, e[1], e[0]);
        end
      end
    end
  endtask

  task automatic observe();
    obs_load  += int'(CTR_LOAD);
    obs_en    += int'(CTR_ENABLE);
    obs_done0 += int'(DONE0);
    obs_done1 += int'(DONE1);
    obs_err   += int'(ERR);
    obs_busy  += int'(BUSY);
    if (DONE0 || DONE1) count_at_done = int'(COUNT);
    if (BUSY && COUNT == '0) saw_zero = 1'b1;
    if (GNT0 && !prev_gnt0) gnt_log.push_back(0);
    if (GNT1 && !prev_gnt1) gnt_log.push_back(1);
    prev_gnt0 = GNT0;
    prev_gnt1 = GNT1;
  endtask

  task automatic step();
    @(posedge CLOCK);
    model_edge();
    #1;
    compare();
    observe();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic drain(input int bound);
    int b;
    b = 0;
    while (m_busy && b < bound) begin
      step();
      b++;
    end
    if (m_busy) chk("drain_timeout", 1, 0);
    step();
  endtask

  // Driver: one request from idle, inputs scrambled right after the grant edge.
  task automatic run_req(input bit who, input logic [W-1:0] s, input logic [W-1:0] p);
    if (who) begin REQ1 = 1'b1; START1 = s; STOP1 = p; end
    else     begin REQ0 = 1'b1; START0 = s; STOP0 = p; end
    step();
    REQ0 = 1'b0; REQ1 = 1'b0;
    START0 = W'($urandom); STOP0 = W'($urandom);
    START1 = W'($urandom); STOP1 = W'($urandom);
    drain(400);
  endtask

  initial begin
    do_reset();
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_data", int'(CTR_DATA), 0);

    // Basic run 10 -> 13
    clear_obs();
    run_req(1'b0, 8'd10, 8'd13);
    chk("basic_load_cycles", obs_load, 1);
    chk("basic_enables", obs_en, 3);
    chk("basic_done0", obs_done0, 1);
    chk("basic_err", obs_err, 0);
    chk("basic_busy_cycles", obs_busy, 6);
    chk("basic_count_at_done", count_at_done, 13);

    // Wrap-around run 250 -> 2 on requester 1
    clear_obs();
    run_req(1'b1, 8'd250, 8'd2);
    chk("wrap_enables", obs_en, 8);
    chk("wrap_saw_zero", int'(saw_zero), 1);
    chk("wrap_done1", obs_done1, 1);
    chk("wrap_count_at_done", count_at_done, 2);

    // start == stop
    clear_obs();
    run_req(1'b0, 8'd77, 8'd77);
    chk("equal_enables", obs_en, 0);
    chk("equal_busy_cycles", obs_busy, 3);
    chk("equal_done0", obs_done0, 1);

    // Stuck counter triggers the watchdog
    clear_obs();
    stuck = 1'b1; stuck_val = '0;
    run_req(1'b0, 8'd0, 8'd5);
    stuck = 1'b0;
    chk("stuck_enables", obs_en, 256);
    chk("stuck_err", obs_err, 1);
    chk("stuck_busy_cycles", obs_busy, 259);

    // Round robin with both requests held from reset
    clear_obs();
    REQ0 = 1'b1; START0 = 8'd0; STOP0 = 8'd1;
    REQ1 = 1'b1; START1 = 8'd5; STOP1 = 8'd6;
    do_reset();
    for (int i = 0; i < 100 && gnt_log.size() < 4; i++) step();
    REQ0 = 1'b0; REQ1 = 1'b0;
    drain(400);
    chk("rr_grants", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", (i < gnt_log.size()) ? gnt_log[i] : -1, i % 2);
    chk("rr_done0", obs_done0, 2);
    chk("rr_done1", obs_done1, 2);

    // Reset in the middle of a run, then a fresh request from 1
    clear_obs();
    REQ0 = 1'b1; START0 = 8'd0; STOP0 = 8'd200;
    step();
    REQ0 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("midreset_busy", int'(BUSY), 0);
    chk("midreset_done_count", obs_done0, 0);
    run_req(1'b1, 8'd3, 8'd4);
    chk("after_reset_done1", obs_done1, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      REQ0 = ($urandom_range(0, 2) == 0);
      REQ1 = ($urandom_range(0, 2) == 0);
      START0 = W'($urandom); STOP0 = START0 + W'($urandom_range(0, 12));
      START1 = W'($urandom); STOP1 = START1 + W'($urandom_range(0, 12));
      if ($urandom_range(0, 40) == 0) STOP1 = W'($urandom);
      RESET = ($urandom_range(0, 400) == 0);
      step();
    end
    RESET = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
    drain(400);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
